// File: rtl/img_loader_if.sv
// img_loader_if: image word stream handshake between a source and the loader
interface img_loader_if #(parameter int IMG_WIDTH = 16);
  logic                 s_valid;
  logic [IMG_WIDTH-1:0] s_data;
  logic                 s_last;
  logic                 s_ready;
  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/img_loader.sv
// img_loader: streams images into two ping-pong pre-SRAM banks and hands full banks to fetch
module img_loader #(
  parameter int IMG_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int IMG_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  img_loader_if.slave           s,
  input  logic                  img_request1,
  input  logic                  img_request2,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [IMG_WIDTH-1:0]  wr_data,
  output logic                  sram_cs1_n,
  output logic                  sram_we1_n,
  output logic                  sram_cs2_n,
  output logic                  sram_we2_n,
  output logic                  pre_sram_full1,
  output logic                  pre_sram_full2,
  output logic                  frame_err
);
  typedef enum logic {S_FILL, S_WAIT} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IMG_WORDS - 1);
  state_t                state, state_d;
  logic                  bank;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [1:0]            cs_n, full, done, req;
  logic                  acc, last_word, nb;
  assign s.s_ready      = state == S_FILL;
  assign sram_cs1_n     = cs_n[0];
  assign sram_we1_n     = cs_n[0];
  assign sram_cs2_n     = cs_n[1];
  assign sram_we2_n     = cs_n[1];
  assign pre_sram_full1 = full[0];
  assign pre_sram_full2 = full[1];
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_FILL;
    else state <= state_d;
  // Next state: stall when the next target bank is still owned by fetch
  always_comb begin
    req       = {img_request2, img_request1};
    acc       = s.s_valid & s.s_ready;
    last_word = cnt == LAST;
    nb        = ~bank;
    state_d   = state;
    if (state == S_WAIT && !full[bank] && !done[bank]) state_d = S_FILL;
    if (acc && last_word) state_d = (full[nb] | done[nb]) ? S_WAIT : S_FILL;
  end
  // Datapath: word counter, bank select, registered SRAM write port, full flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bank      <= 1'b0;
      cnt       <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cs_n      <= 2'b11;
      done      <= 2'b00;
      full      <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      cnt       <= acc ? (last_word ? '0 : cnt + ADDR_WIDTH'(1)) : cnt;
      bank      <= bank ^ (acc & last_word);
      cs_n      <= acc ? ~(2'b01 << bank) : 2'b11;
      done      <= (acc && last_word) ? (2'b01 << bank) : 2'b00;
      full      <= done | (full & ~req);
      frame_err <= frame_err | (acc & (s.s_last ^ last_word));
      if (acc) begin
        wr_addr <= cnt;
        wr_data <= s.s_data;
      end
    end
endmodule

// File: tb/tb_img_loader.sv
// tb_img_loader: random stream stimulus checked against a behavioural ping-pong loader model
module tb_img_loader;
  localparam int W = 16, A = 10, N = 1024;
  logic clk = 1'b0, rst = 1'b0, img_request1 = 1'b0, img_request2 = 1'b0;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic sram_cs1_n, sram_we1_n, sram_cs2_n, sram_we2_n;
  logic pre_sram_full1, pre_sram_full2, frame_err;
  int checks = 0, failures = 0;
  int edge_n = 0, m_bank = 0, m_cnt = 0, a_bank = 0, a_addr = 0;
  int set_edge [2] = '{-1, -1};
  bit [1:0] m_full = 2'b00, m_pfull = 2'b00;
  bit m_ferr = 1'b0, m_acc = 1'b0;
  logic [W-1:0] a_data = '0;
  img_loader_if #(.IMG_WIDTH(W)) sif ();
  img_loader #(.IMG_WIDTH(W), .ADDR_WIDTH(A), .IMG_WORDS(N)) dut (
    .clk(clk), .rst(rst), .s(sif),
    .img_request1(img_request1), .img_request2(img_request2),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .sram_cs1_n(sram_cs1_n), .sram_we1_n(sram_we1_n),
    .sram_cs2_n(sram_cs2_n), .sram_we2_n(sram_we2_n),
    .pre_sram_full1(pre_sram_full1), .pre_sram_full2(pre_sram_full2),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_bank = 0; m_cnt = 0; m_full = 2'b00; m_pfull = 2'b00;
    m_ferr = 1'b0; m_acc = 1'b0; set_edge = '{-1, -1};
  endtask
  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  // A bank turns full one edge after its last word is taken; a request returns a full bank;
  // the loader takes words while its target bank was free both now and in the previous cycle.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit l, input bit r1, input bit r2);
    sif.s_valid = v; sif.s_data = d; sif.s_last = l;
    img_request1 = r1; img_request2 = r2;
    @(posedge clk);
    edge_n++;
    m_acc = v && !m_full[m_bank] && !m_pfull[m_bank];
    m_pfull = m_full;
    for (int b = 0; b < 2; b++)
      if (set_edge[b] == edge_n) m_full[b] = 1'b1;
      else if ((b == 0) ? r1 : r2) m_full[b] = 1'b0;
    if (m_acc) begin
      a_bank = m_bank; a_addr = m_cnt; a_data = d;
      if (l != (m_cnt == N - 1)) m_ferr = 1'b1;
      if (m_cnt == N - 1) begin
        set_edge[m_bank] = edge_n + 1;
        m_cnt = 0;
        m_bank ^= 1;
      end else m_cnt++;
    end
    @(negedge clk);
    check("s_ready", sif.s_ready, !m_full[m_bank] && !m_pfull[m_bank]);
    check("strobes", {sram_cs1_n, sram_we1_n, sram_cs2_n, sram_we2_n},
          !m_acc ? 4'hf : (a_bank == 0 ? 4'h3 : 4'hc));
    check("full", {pre_sram_full2, pre_sram_full1}, m_full);
    check("frame_err", frame_err, m_ferr);
    if (m_acc) begin
      check("wr_addr", wr_addr, a_addr);
      check("wr_data", wr_data, a_data);
    end
  endtask
  // bad: 0 clean, 1 extra s_last at word 500, 2 s_last missing on the final word
  task automatic stream(input int n, input int base, input int gap, input bit rnd, input bit rq, input int bad);
    int i = 0, budget = 0;
    while (i < n && budget < 20 * N) begin
      cyc($urandom_range(99) >= gap, rnd ? W'($urandom) : W'(base + i),
          ((i == N - 1) && bad != 2) || (bad == 1 && i == 500),
          rq && $urandom_range(15) == 0, rq && $urandom_range(15) == 0);
      if (m_acc) i++;
      budget++;
    end
    check("words", i, n);
  endtask
  initial begin
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_strobes", {sram_cs1_n, sram_we1_n, sram_cs2_n, sram_we2_n}, 4'hf);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_full", {pre_sram_full2, pre_sram_full1}, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ready", sif.s_ready, 1);
    rst = 1'b1;
    stream(N, 0, 0, 1'b0, 1'b0, 0);
    check("full1_early", pre_sram_full1, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("full1_set_wins", pre_sram_full1, 1);
    check("req2_ignored", pre_sram_full2, 0);
    check("ferr_clean", frame_err, 0);
    stream(N, 1000, 0, 1'b0, 1'b0, 0);
    repeat (2) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
    check("wait_ready", sif.s_ready, 0);
    check("full2", pre_sram_full2, 1);
    cyc(1'b1, '0, 1'b0, 1'b1, 1'b0);
    check("req1_clear", pre_sram_full1, 0);
    check("ready_lag", sif.s_ready, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("ready_back", sif.s_ready, 1);
    stream(N, 2000, 0, 1'b0, 1'b0, 0);
    repeat (3) stream(N, 0, 30, 1'b1, 1'b1, 0);
    stream(N, 0, 20, 1'b1, 1'b1, 1);
    check("ferr_early_last", frame_err, 1);
    stream(N, 0, 20, 1'b1, 1'b1, 2);
    check("ferr_sticky", frame_err, 1);
    if (m_bank == 0) stream(N, 0, 10, 1'b1, 1'b1, 0);
    stream(300, 0, 10, 1'b1, 1'b1, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_strobes", {sram_cs1_n, sram_we1_n, sram_cs2_n, sram_we2_n}, 4'hf);
    check("arst_addr", wr_addr, 0);
    check("arst_data", wr_data, 0);
    check("arst_full", {pre_sram_full2, pre_sram_full1}, 0);
    check("arst_ferr", frame_err, 0);
    check("arst_ready", sif.s_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    stream(1, 77, 0, 1'b0, 1'b0, 0);
    check("restart_bank1", {sram_cs1_n, sram_we1_n}, 0);
    check("restart_addr0", wr_addr, 0);
    stream(40, 78, 30, 1'b1, 1'b0, 0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
